// File: rtl/nibble_serial_adder.sv
// Multi-word adder sequencer: feeds an external 4-bit ripple-carry adder one nibble per cycle, LSB first.
// Optional signed-overflow flag is built only when NSA_OVERFLOW_EN is defined.
module nibble_serial_adder #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES,
  localparam int IW = $clog2(NIBBLES)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic         cin_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf,
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_cin,
  input  logic [3:0]   add_sum,
  input  logic         add_cout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [NIBBLES-1:0][3:0] a_reg, b_reg, res_q;
  logic                    carry_reg, cout_q;
  logic [IW-1:0]           idx;
  logic                    last;

  assign last = (idx == IW'(NIBBLES - 1));

  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_q     <= '0;
      carry_reg <= 1'b0;
      cout_q    <= 1'b0;
      idx       <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          a_reg     <= a_in;
          b_reg     <= b_in;
          carry_reg <= cin_in;
          idx       <= '0;
          res_q     <= '0;
          cout_q    <= 1'b0;
        end
        RUN: begin
          res_q[idx] <= add_sum;
          carry_reg  <= add_cout;
          // idx parks on the last slice instead of wrapping.
          if (last) cout_q <= add_cout;
          else      idx    <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef NSA_OVERFLOW_EN
  logic ovf_q;

  // Signed overflow: equal operand signs but the final sum sign differs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      ovf_q <= 1'b0;
    end else if (state_q == RUN && last) begin
      ovf_q <= (a_reg[NIBBLES-1][3] == b_reg[NIBBLES-1][3]) &&
               (add_sum[3] != a_reg[NIBBLES-1][3]);
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  always_comb begin
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    if (state_q == RUN) begin
      add_a   = a_reg[idx];
      add_b   = b_reg[idx];
      add_cin = carry_reg;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign result = res_q;
  assign cout   = cout_q;

endmodule
